instruction_sequencer: RTL and testbench

Control block that sequences `register_block` through the four-step instruction cycle. It fetches an instruction word, decodes source/destination/effect fields and drives the register block's step, select and strobe inputs. It inserts wait cycles while external memory reads or writes are pending and stops on a halt instruction. It sits between the memory interface and `register_block`/ALU in the reference CPU.

---
 rtl/ucisc_pkg.sv | 48 ++++
 rtl/instruction_decoder.sv | 29 ++
 rtl/instruction_sequencer.sv | 150 +++++++++++++++
 tb/tb_instruction_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ucisc_pkg.sv
// Shared types, register codes and operand helpers for the instruction sequencer.
package ucisc_pkg;

  localparam logic [15:0] HALT_WORD = 16'h0000;

  localparam logic [3:0] REG_PC    = 4'd0;
  localparam logic [3:0] REG_IMM   = 4'd4;
  localparam logic [3:0] REG_FLAGS = 4'd8;

  localparam logic [1:0] STEP_FETCH = 2'd0;
  localparam logic [1:0] STEP_LOAD  = 2'd1;
  localparam logic [1:0] STEP_EXEC  = 2'd2;
  localparam logic [1:0] STEP_STORE = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_EXEC,
    ST_STORE,
    ST_HALT
  } state_e;

  typedef enum logic [1:0] {
    EFF_ALWAYS      = 2'b00,
    EFF_IF_ZERO     = 2'b01,
    EFF_IF_NOT_ZERO = 2'b10,
    EFF_FLAGS_ONLY  = 2'b11
  } effect_e;

  // Bit 2 (the immediate / register-direct bit) clear and a non-zero low pair
  // selects a memory operand: codes 1-3 and 9-B.
  function automatic logic is_mem_operand(input logic [3:0] code);
    return ((code & REG_IMM) == 4'd0) && (code[1:0] != 2'b00);
  endfunction

  function automatic logic store_allowed(input effect_e effect, input logic zero);
    logic allow;
    case (effect)
      EFF_ALWAYS:      allow = 1'b1;
      EFF_IF_ZERO:     allow = zero;
      EFF_IF_NOT_ZERO: allow = ~zero;
      default:         allow = 1'b0;
    endcase
    return allow;
  endfunction

endpackage

// File: rtl/instruction_decoder.sv
// Combinational field extraction and operand classification of the latched instruction.
module instruction_decoder
  import ucisc_pkg::*;
(
  input  logic [15:0] instr,
  output logic [3:0]  src,
  output logic [3:0]  dst,
  output logic [3:0]  alu,
  output effect_e     effect,
  output logic        push_bit,
  output logic        pop_bit,
  output logic        src_mem,
  output logic        dst_mem,
  output logic        dst_is_pc,
  output logic        dst_is_flags
);

  assign dst          = instr[15:12];
  assign src          = instr[11:8];
  assign push_bit     = instr[7];
  assign pop_bit      = instr[6];
  assign effect       = effect_e'(instr[5:4]);
  assign alu          = instr[3:0];
  assign src_mem      = is_mem_operand(instr[11:8]);
  assign dst_mem      = is_mem_operand(instr[15:12]);
  assign dst_is_pc    = (instr[15:12] == REG_PC);
  assign dst_is_flags = (instr[15:12] == REG_FLAGS);

endmodule

// File: rtl/instruction_sequencer.sv
// Four-step instruction sequencer driving register_block step/select/strobe inputs.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | paused by run=0, waits for run
// FETCH    | read instruction word; first cycle after reset only checks run
// LOAD     | fetch source operand, waits on memory for memory operands
// EXEC     | one cycle, store decision taken from flags into commit
// STORE    | write destination / flags, PC increment on exit
// HALT     | halt word seen, left only through reset
module instruction_sequencer
  import ucisc_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] instruction,
  input  logic        mem_ready,
  input  logic [15:0] flags,
  output logic [1:0]  step,
  output logic [3:0]  desired_source,
  output logic [3:0]  desired_destination,
  output logic        write_enable,
  output logic        write_flags,
  output logic        inc_enable,
  output logic        push,
  output logic        pop,
  output logic        mem_read_req,
  output logic        mem_write_req,
  output logic [3:0]  alu_code,
  output logic        halted
);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        commit_q, commit_d;
  logic        armed_q, armed_d;
  logic        store_done;

  effect_e     effect;
  logic        push_bit, pop_bit, src_mem, dst_mem, dst_is_pc, dst_is_flags;

  // Only the zero flag steers the store decision.
  logic        unused_flags;
  assign unused_flags = ^flags[15:1];

  instruction_decoder u_decoder (
    .instr        (ir_q),
    .src          (desired_source),
    .dst          (desired_destination),
    .alu          (alu_code),
    .effect       (effect),
    .push_bit     (push_bit),
    .pop_bit      (pop_bit),
    .src_mem      (src_mem),
    .dst_mem      (dst_mem),
    .dst_is_pc    (dst_is_pc),
    .dst_is_flags (dst_is_flags)
  );

  // State, latched instruction and commit decision; reset parks in FETCH with no request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_FETCH;
      ir_q     <= '0;
      commit_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      commit_q <= commit_d;
      armed_q  <= armed_d;
    end
  end

  // Next-state and strobe decode; wait states extend while mem_ready is low under a request.
  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    commit_d      = commit_q;
    armed_d       = 1'b1;
    store_done    = 1'b0;
    step          = STEP_FETCH;
    write_enable  = 1'b0;
    write_flags   = 1'b0;
    inc_enable    = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;
    mem_read_req  = 1'b0;
    mem_write_req = 1'b0;
    halted        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        // armed_q is low only in the first cycle out of reset: decide run/pause
        // there without issuing a read.
        if (!armed_q) begin
          state_d = run ? ST_FETCH : ST_IDLE;
        end else begin
          mem_read_req = 1'b1;
          if (mem_ready) begin
            ir_d    = instruction;
            state_d = (instruction == HALT_WORD) ? ST_HALT : ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        step = STEP_LOAD;
        if (src_mem) begin
          mem_read_req = 1'b1;
          if (mem_ready) begin
            pop     = pop_bit;
            state_d = ST_EXEC;
          end
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        step     = STEP_EXEC;
        commit_d = store_allowed(effect, flags[0]);
        state_d  = ST_STORE;
      end
      ST_STORE: begin
        step         = STEP_STORE;
        write_enable = commit_q;
        store_done   = 1'b1;
        if (commit_q && dst_mem) begin
          mem_write_req = 1'b1;
          store_done    = mem_ready;
        end
        if (store_done) begin
          write_flags = ~dst_is_flags;
          push        = commit_q & push_bit;
          inc_enable  = ~(commit_q & dst_is_pc);
          state_d     = run ? ST_FETCH : ST_IDLE;
        end
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench: each instruction is expanded into a per-cycle trace of inputs and
// expected outputs; one process compares the DUT against that trace every cycle.
module tb_instruction_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        run;
  logic [15:0] instruction;
  logic        mem_ready;
  logic [15:0] flags;
  logic [1:0]  step;
  logic [3:0]  desired_source;
  logic [3:0]  desired_destination;
  logic        write_enable;
  logic        write_flags;
  logic        inc_enable;
  logic        push;
  logic        pop;
  logic        mem_read_req;
  logic        mem_write_req;
  logic [3:0]  alu_code;
  logic        halted;

  instruction_sequencer dut (
    .clock               (clock),
    .reset               (reset),
    .run                 (run),
    .instruction         (instruction),
    .mem_ready           (mem_ready),
    .flags               (flags),
    .step                (step),
    .desired_source      (desired_source),
    .desired_destination (desired_destination),
    .write_enable        (write_enable),
    .write_flags         (write_flags),
    .inc_enable          (inc_enable),
    .push                (push),
    .pop                 (pop),
    .mem_read_req        (mem_read_req),
    .mem_write_req       (mem_write_req),
    .alu_code            (alu_code),
    .halted              (halted)
  );

  always #5 clock = ~clock;

  // exp layout: {step[21:20], src[19:16], dst[15:12], alu[11:8],
  //              we[7], wf[6], inc[5], push[4], pop[3], rreq[2], wreq[1], halted[0]}
  typedef struct {
    logic        run;
    logic        mr;
    logic [15:0] instr;
    logic [15:0] flg;
    logic [21:0] exp;
  } cyc_t;

  cyc_t        stim_q[$];
  cyc_t        chk_q[$];
  cyc_t        cmp_c;
  int          checks = 0;
  int          errors = 0;
  int          cyc_no = 0;
  int          n0;
  logic [15:0] m_ir;
  logic [21:0] act_v;

  assign act_v = {step, desired_source, desired_destination, alu_code,
                  write_enable, write_flags, inc_enable, push, pop,
                  mem_read_req, mem_write_req, halted};

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic mem_op(input logic [3:0] c);
    return (c[2] == 1'b0) && (c[1:0] != 2'b00);
  endfunction

  // Expected output vector; the latched fields always show the last fetched word.
  function automatic logic [21:0] outv(input logic [1:0] st, input logic we, input logic wf,
                                       input logic inc, input logic ps, input logic pp,
                                       input logic rr, input logic wr, input logic h);
    return {st, m_ir[11:8], m_ir[15:12], m_ir[3:0], we, wf, inc, ps, pp, rr, wr, h};
  endfunction

  task automatic add(input logic r, input logic mr, input logic [15:0] ins,
                     input logic [15:0] flg, input logic [21:0] e);
    cyc_t c;
    c.run = r; c.mr = mr; c.instr = ins; c.flg = flg; c.exp = e;
    stim_q.push_back(c);
  endtask

  task automatic add_post_reset(input logic r);
    add(r, rnd(), 16'hFFFF, 16'h0000, outv(2'd0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic add_idle(input int n, input logic r_last);
    for (int i = 0; i < n; i++)
      add((i == n - 1) ? r_last : 1'b0, rnd(), 16'hFFFF, 16'h0000,
          outv(2'd0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic add_halted(input int n);
    for (int i = 0; i < n; i++)
      add(rnd(), rnd(), 16'($urandom), 16'($urandom), outv(2'd0, 0, 0, 0, 0, 0, 0, 0, 1));
  endtask

  // One instruction: fetch (wf_n waits), load (wl_n waits if memory source),
  // exec, store (ws_n waits if committed memory destination).
  task automatic expand(input logic [15:0] ins, input logic [15:0] flg, input int wf_n,
                        input int wl_n, input int ws_n, input logic r_end);
    logic [3:0] s, d;
    logic       commit, wrmem;
    for (int i = 0; i < wf_n; i++) add(1'b1, 1'b0, ins, flg, outv(2'd0, 0, 0, 0, 0, 0, 1, 0, 0));
    add(1'b1, 1'b1, ins, flg, outv(2'd0, 0, 0, 0, 0, 0, 1, 0, 0));
    m_ir = ins;
    if (ins == 16'h0000) return;
    s = ins[11:8];
    d = ins[15:12];
    if (mem_op(s)) begin
      for (int i = 0; i < wl_n; i++) add(r_end, 1'b0, ins, flg, outv(2'd1, 0, 0, 0, 0, 0, 1, 0, 0));
      add(r_end, 1'b1, ins, flg, outv(2'd1, 0, 0, 0, 0, ins[6], 1, 0, 0));
    end else begin
      add(r_end, rnd(), ins, flg, outv(2'd1, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    add(r_end, rnd(), ins, flg, outv(2'd2, 0, 0, 0, 0, 0, 0, 0, 0));
    case (ins[5:4])
      2'b00:   commit = 1'b1;
      2'b01:   commit = flg[0];
      2'b10:   commit = ~flg[0];
      default: commit = 1'b0;
    endcase
    wrmem = commit && mem_op(d);
    if (wrmem)
      for (int i = 0; i < ws_n; i++) add(r_end, 1'b0, ins, flg, outv(2'd3, 1, 0, 0, 0, 0, 0, 1, 0));
    add(r_end, wrmem ? 1'b1 : rnd(), ins, flg,
        outv(2'd3, commit, d != 4'd8, !(commit && d == 4'd0), commit && ins[7], 0, 0, wrmem, 0));
  endtask

  // Pin the model's store-cycle strobes for the instruction just expanded.
  task automatic pin_store(input string name, input logic we, input logic wf, input logic inc);
    cyc_t last;
    last = stim_q[$];
    check({name, "_model_we"},  last.exp[7], we);
    check({name, "_model_wf"},  last.exp[6], wf);
    check({name, "_model_inc"}, last.exp[5], inc);
  endtask

  // Entered at posedge+1; each record's inputs are held for one full cycle.
  task automatic play_n(input int n);
    cyc_t c;
    for (int i = 0; i < n && stim_q.size() > 0; i++) begin
      c = stim_q.pop_front();
      run = c.run; mem_ready = c.mr; instruction = c.instr; flags = c.flg;
      chk_q.push_back(c);
      @(posedge clock);
      #1;
    end
  endtask

  task automatic play();
    play_n(stim_q.size());
  endtask

  // Single compare point, mid-cycle, against the trace record for this cycle.
  always @(negedge clock) begin
    if (chk_q.size() > 0) begin
      cmp_c = chk_q.pop_front();
      check($sformatf("cycle_%0d", cyc_no), {10'd0, act_v}, {10'd0, cmp_c.exp});
      cyc_no++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; run = 1'b0; mem_ready = 1'b0; instruction = 16'h0000; flags = 16'h0000;
    m_ir = 16'h0000;
    repeat (3) @(posedge clock);
    #1;
    check("reset_step", step, 2'd0);
    check("reset_rreq", mem_read_req, 1'b0);
    check("reset_halted", halted, 1'b0);
    check("reset_we", write_enable, 1'b0);
    check("reset_dst", desired_destination, 4'd0);

    add_post_reset(1'b1);
    n0 = stim_q.size(); expand(16'h5600, 16'h0000, 0, 0, 0, 1'b1);
    check("len_5600", stim_q.size() - n0, 4);
    pin_store("i5600", 1'b1, 1'b1, 1'b1);
    n0 = stim_q.size(); expand(16'h1200, 16'h0000, 0, 3, 2, 1'b1);
    check("len_1200_waits", stim_q.size() - n0, 9);
    expand(16'h5610, 16'h0000, 2, 0, 0, 1'b1);
    pin_store("i5610_f0", 1'b0, 1'b1, 1'b1);
    expand(16'h5610, 16'h0001, 0, 0, 0, 1'b1);
    pin_store("i5610_f1", 1'b1, 1'b1, 1'b1);
    expand(16'h0400, 16'h0000, 1, 0, 0, 1'b1);
    pin_store("i0400", 1'b1, 1'b1, 1'b0);
    expand(16'hBAE5, 16'h0000, 0, 1, 1, 1'b1);
    expand(16'h8C3F, 16'h0001, 0, 0, 0, 1'b1);
    pin_store("i8C3F", 1'b0, 1'b0, 1'b1);
    expand(16'h2170, 16'h0000, 0, 2, 0, 1'b0);
    add_idle(3, 1'b1);
    expand(16'h5600, 16'h0000, 0, 0, 0, 1'b1);
    expand(16'h0000, 16'h0000, 1, 0, 0, 1'b1);
    add_halted(20);
    reset = 1'b1;
    play();

    // Leave HALT through reset, then come back up with run low.
    reset = 1'b0;
    #1;
    check("halt_reset_halted", halted, 1'b0);
    check("halt_reset_step", step, 2'd0);
    repeat (2) @(posedge clock);
    #1;
    m_ir = 16'h0000;
    add_post_reset(1'b0);
    add_idle(2, 1'b1);
    expand(16'h5600, 16'h0000, 0, 0, 0, 1'b1);
    reset = 1'b1;
    play();

    // Reset in the middle of a LOAD memory wait.
    expand(16'h1200, 16'h0000, 0, 5, 0, 1'b1);
    play_n(3);
    check("load_wait_rreq", mem_read_req, 1'b1);
    check("load_wait_step", step, 2'd1);
    reset = 1'b0;
    #1;
    check("mid_reset_rreq", mem_read_req, 1'b0);
    check("mid_reset_step", step, 2'd0);
    check("mid_reset_inc", inc_enable, 1'b0);
    check("mid_reset_src", desired_source, 4'd0);
    stim_q.delete();
    repeat (3) begin
      @(negedge clock);
      check("reset_hold_inc", inc_enable, 1'b0);
      check("reset_hold_we", write_enable, 1'b0);
    end
    @(posedge clock);
    #1;
    m_ir = 16'h0000;
    add_post_reset(1'b1);
    expand(16'h5600, 16'h0000, 0, 0, 0, 1'b1);
    reset = 1'b1;
    play();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
